// File: rtl/cnn_result_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : cnn_result_monitor_if
// Description : Stimulus and result bundle of the CNN result monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnn_result_monitor_if #(
   parameter int CLASS_W     = 4,
   parameter int NUM_CLASSES = 10,
   parameter int CNT_W       = 4,
   parameter int ADDR_W      = 19
);
   logic                         start;
   logic [CLASS_W-1:0]           expected_class;
   logic [CLASS_W-1:0]           class_in;
   logic                         class_valid;
   logic [ADDR_W-1:0]            address;
   logic [CNT_W-1:0]             error_count;
   logic [CNT_W-1:0]             total_count;
   logic [NUM_CLASSES*CNT_W-1:0] hist_flat;
   logic                         error_pulse;
   logic                         busy;
   logic                         done;
   logic                         bad_class;
   logic                         saturated;

   modport master (
      output start, expected_class, class_in, class_valid, address,
      input  error_count, total_count, hist_flat, error_pulse,
             busy, done, bad_class, saturated
   );

   modport slave (
      input  start, expected_class, class_in, class_valid, address,
      output error_count, total_count, hist_flat, error_pulse,
             busy, done, bad_class, saturated
   );
endinterface
`default_nettype wire

// File: rtl/cnn_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cnn_result_monitor
// Description : Checks CNN classifications against an expected class and keeps
//               saturating error/total/histogram counters under run control.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_result_monitor #(
   parameter int CLASS_W     = 4,
   parameter int NUM_CLASSES = 10,
   parameter int CNT_W       = 4,
   parameter int ADDR_W      = 19,
   parameter int ADDR_LIMIT  = 512000,
   parameter int MAX_EVENTS  = 0,
   parameter int USE_VALID   = 0
) (
   input  wire logic           clk,
   input  wire logic           reset,
   cnn_result_monitor_if.slave mon
);
   localparam logic [CNT_W-1:0]  c_CNT_MAX    = '1;
   localparam logic [ADDR_W-1:0] c_ADDR_LIMIT = ADDR_W'(ADDR_LIMIT);
   localparam logic [CNT_W-1:0]  c_MAX_EVENTS = CNT_W'(MAX_EVENTS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_q1, r_q2, r_evt;
   logic [CLASS_W-1:0] r_cls_evt, r_exp;
   logic [CNT_W-1:0]   r_err, r_tot;
   logic [CNT_W-1:0]   r_hist [NUM_CLASSES];
   logic               r_pulse, r_busy, r_done, r_bad, r_sat;

   logic               w_max_hit, w_in_window, w_in_range, w_mismatch, w_count, w_sat_hit;
   logic [CNT_W-1:0]   w_err_nxt, w_tot_nxt;
   logic [CNT_W-1:0]   w_hist_nxt [NUM_CLASSES];

   assign w_max_hit   = (MAX_EVENTS != 0) && (r_tot == c_MAX_EVENTS);
   assign w_in_window = (mon.address <= c_ADDR_LIMIT);
   assign w_in_range  = (int'(r_cls_evt) < NUM_CLASSES);
   assign w_mismatch  = (r_cls_evt != r_exp);
   // A start on the same edge always wins over a pending event.
   assign w_count     = (r_state == S_RUN) && r_evt && w_in_window && !w_max_hit && !mon.start;

   always_comb begin
      w_err_nxt  = r_err;
      w_tot_nxt  = r_tot;
      w_hist_nxt = r_hist;
      if (w_count) begin
         if (r_tot != c_CNT_MAX) w_tot_nxt = r_tot + 1'b1;
         if (w_mismatch && (r_err != c_CNT_MAX)) w_err_nxt = r_err + 1'b1;
         for (int k = 0; k < NUM_CLASSES; k++) begin
            if (w_in_range && (r_cls_evt == CLASS_W'(k)) && (r_hist[k] != c_CNT_MAX))
               w_hist_nxt[k] = r_hist[k] + 1'b1;
         end
      end
      w_sat_hit = (w_err_nxt == c_CNT_MAX) || (w_tot_nxt == c_CNT_MAX);
      for (int k = 0; k < NUM_CLASSES; k++) begin
         if (w_hist_nxt[k] == c_CNT_MAX) w_sat_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_q1      <= 1'b0;
         r_q2      <= 1'b0;
         r_evt     <= 1'b0;
         r_cls_evt <= '0;
         r_exp     <= '0;
         r_err     <= '0;
         r_tot     <= '0;
         for (int k = 0; k < NUM_CLASSES; k++) r_hist[k] <= '0;
         r_pulse   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bad     <= 1'b0;
         r_sat     <= 1'b0;
      end else begin
         // Detector runs in every state; edge mode fires on class_in leaving zero.
         r_q1      <= (mon.class_in != '0);
         r_q2      <= r_q1;
         r_evt     <= (USE_VALID != 0) ? mon.class_valid : (r_q1 & ~r_q2);
         r_cls_evt <= mon.class_in;
         r_pulse   <= 1'b0;
         if (mon.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_exp   <= mon.expected_class;
            r_err   <= '0;
            r_tot   <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) r_hist[k] <= '0;
            r_bad   <= 1'b0;
            r_sat   <= 1'b0;
         end else if (r_state == S_RUN) begin
            r_err   <= w_err_nxt;
            r_tot   <= w_tot_nxt;
            r_hist  <= w_hist_nxt;
            r_sat   <= r_sat | w_sat_hit;
            r_bad   <= r_bad | (w_count & ~w_in_range);
            r_pulse <= w_count & w_mismatch;
            if (!w_in_window || w_max_hit) begin
               r_state <= S_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
         end
      end
   end

   generate
      for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_hist_flat
         assign mon.hist_flat[k*CNT_W +: CNT_W] = r_hist[k];
      end
   endgenerate

   assign mon.error_count = r_err;
   assign mon.total_count = r_tot;
   assign mon.error_pulse = r_pulse;
   assign mon.busy        = r_busy;
   assign mon.done        = r_done;
   assign mon.bad_class   = r_bad;
   assign mon.saturated   = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_cnn_result_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_result_monitor
// Description : Self-checking bench: edge-mode and strobe-mode monitors driven
//               in lockstep against a sample-history reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_result_monitor;
   localparam int NC = 10;
   localparam int AL = 512000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  expc = '0;
   logic [3:0]  cin = '0;
   logic        cv = 1'b0;
   logic [18:0] addr = '0;

   always #5 clk = ~clk;

   cnn_result_monitor_if if0 ();
   cnn_result_monitor_if if1 ();

   assign if0.start = start;  assign if0.expected_class = expc;
   assign if0.class_in = cin; assign if0.class_valid = cv; assign if0.address = addr;
   assign if1.start = start;  assign if1.expected_class = expc;
   assign if1.class_in = cin; assign if1.class_valid = cv; assign if1.address = addr;

   cnn_result_monitor #(.USE_VALID(0), .MAX_EVENTS(0)) dut0 (.clk(clk), .reset(reset), .mon(if0));
   cnn_result_monitor #(.USE_VALID(1), .MAX_EVENTS(4)) dut1 (.clk(clk), .reset(reset), .mon(if1));

   logic [52:0] act0, act1;
   assign act0 = {if0.error_count, if0.total_count, if0.hist_flat, if0.error_pulse,
                  if0.busy, if0.done, if0.bad_class, if0.saturated};
   assign act1 = {if1.error_count, if1.total_count, if1.hist_flat, if1.error_pulse,
                  if1.busy, if1.done, if1.bad_class, if1.saturated};

   int n_checks = 0;
   int n_errors = 0;
   int pulses0  = 0;

   // Reference model: state 0=idle 1=run 2=done; h1/h2/h3 = class_in one/two/three edges back.
   int m_state[2], m_err[2], m_tot[2], m_exp[2], m_max[2];
   int m_hist[2][NC];
   bit m_bad[2], m_pulse[2];
   int h1, h2, h3;
   bit hv1;

   function automatic int sat_inc(int v);
      return (v < 15) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0; m_err[d] = 0; m_tot[d] = 0; m_exp[d] = 0;
         m_bad[d] = 0; m_pulse[d] = 0;
         for (int k = 0; k < NC; k++) m_hist[d][k] = 0;
      end
      h1 = 0; h2 = 0; h3 = 0; hv1 = 0;
   endtask

   task automatic model_edge();
      bit evt, maxhit, counted;
      if (!reset) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 2; d++) begin
         evt    = (d == 0) ? (h2 != 0 && h3 == 0) : hv1;
         maxhit = (m_max[d] != 0) && (m_tot[d] == m_max[d]);
         m_pulse[d] = 0;
         if (start) begin
            m_state[d] = 1; m_err[d] = 0; m_tot[d] = 0; m_bad[d] = 0;
            m_exp[d] = int'(expc);
            for (int k = 0; k < NC; k++) m_hist[d][k] = 0;
         end else if (m_state[d] == 1) begin
            counted = evt && (int'(addr) <= AL) && !maxhit;
            if (counted) begin
               m_tot[d] = sat_inc(m_tot[d]);
               if (h1 < NC) m_hist[d][h1] = sat_inc(m_hist[d][h1]);
               else m_bad[d] = 1;
               if (h1 != m_exp[d]) begin
                  m_err[d] = sat_inc(m_err[d]);
                  m_pulse[d] = 1;
               end
            end
            if (int'(addr) > AL || maxhit) m_state[d] = 2;
         end
      end
      h3 = h2; h2 = h1; h1 = int'(cin); hv1 = cv;
   endtask

   function automatic logic [52:0] exp_vec(int d);
      logic [39:0] hf;
      logic s;
      hf = '0;
      s = (m_err[d] == 15) || (m_tot[d] == 15);
      for (int k = 0; k < NC; k++) begin
         hf[k*4 +: 4] = 4'(m_hist[d][k]);
         if (m_hist[d][k] == 15) s = 1'b1;
      end
      return {4'(m_err[d]), 4'(m_tot[d]), hf, m_pulse[d],
              m_state[d] == 1, m_state[d] == 2, m_bad[d], s};
   endfunction

   task automatic check_all();
      logic [52:0] a, e;
      for (int d = 0; d < 2; d++) begin
         a = (d == 0) ? act0 : act1;
         e = exp_vec(d);
         n_checks++;
         if (a !== e) begin
            n_errors++;
            $display("FAIL model_dut%0d t=%0t actual=%h required=%h", d, $time, a, e);
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      if (if0.error_pulse) pulses0++;
   endtask

   task automatic do_start(input logic [3:0] e);
      start = 1'b1; expc = e;
      tick();
      start = 1'b0;
   endtask

   task automatic edge_event(input logic [3:0] c);
      cin = c; tick(); tick();
      cin = 4'd0; tick(); tick();
   endtask

   function automatic int hist0(int k);
      return int'(if0.hist_flat[k*4 +: 4]);
   endfunction

   function automatic int hist1(int k);
      return int'(if1.hist_flat[k*4 +: 4]);
   endfunction

   typedef struct {
      int cls; int hold; int tot; int err; int bad;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int   pidx, p0;

      tbl[0] = '{7, 20, 1, 0, 0};
      tbl[1] = '{3,  3, 2, 1, 0};
      tbl[2] = '{12, 3, 3, 2, 1};
      tbl[3] = '{9,  3, 4, 3, 1};
      tbl[4] = '{7,  5, 5, 3, 1};

      m_max[0] = 0; m_max[1] = 4;
      model_reset();

      repeat (3) tick();
      chk("reset_total", int'(if0.total_count), 0);
      chk("reset_busy", int'(if0.busy), 0);
      reset = 1'b1;
      tick();

      // Edge-mode event table, expected class 7
      do_start(4'd7);
      for (int i = 0; i < 5; i++) begin
         p0 = pulses0; pidx = 0;
         cin = 4'(tbl[i].cls);
         for (int j = 1; j <= tbl[i].hold; j++) begin
            tick();
            if (if0.error_pulse) pidx = j;
         end
         cin = 4'd0;
         repeat (3) tick();
         chk($sformatf("tbl%0d_total", i), int'(if0.total_count), tbl[i].tot);
         chk($sformatf("tbl%0d_err", i), int'(if0.error_count), tbl[i].err);
         chk($sformatf("tbl%0d_bad", i), int'(if0.bad_class), tbl[i].bad);
         chk($sformatf("tbl%0d_pulses", i), pulses0 - p0, (tbl[i].cls != 7) ? 1 : 0);
         chk($sformatf("tbl%0d_pulse_lat", i), pidx, (tbl[i].cls != 7) ? 3 : 0);
      end
      chk("hist7", hist0(7), 2);
      chk("hist3", hist0(3), 1);

      // Nonzero-to-nonzero change is one event carrying the first class
      cin = 4'd5; repeat (3) tick();
      cin = 4'd6; repeat (3) tick();
      cin = 4'd0; repeat (3) tick();
      chk("nz_nz_total", int'(if0.total_count), 6);
      chk("nz_nz_hist5", hist0(5), 1);
      chk("nz_nz_hist6", hist0(6), 0);

      // Saturation
      do_start(4'd7);
      p0 = pulses0;
      repeat (20) edge_event(4'd1);
      chk("sat_pulses", pulses0 - p0, 20);
      chk("sat_err", int'(if0.error_count), 15);
      chk("sat_total", int'(if0.total_count), 15);
      chk("sat_flag", int'(if0.saturated), 1);

      // Address window boundary
      do_start(4'd2);
      addr = 19'd511999; edge_event(4'd2);
      addr = 19'd512000; edge_event(4'd2);
      chk("win_total_in", int'(if0.total_count), 2);
      chk("win_busy_in", int'(if0.busy), 1);
      addr = 19'd512001; edge_event(4'd2);
      chk("win_total_out", int'(if0.total_count), 2);
      chk("win_done", int'(if0.done), 1);
      chk("win_busy_out", int'(if0.busy), 0);
      addr = '0;

      // Strobe mode back-to-back
      do_start(4'd7);
      cv = 1'b1; cin = 4'd2; tick(); tick();
      cin = 4'd12; tick();
      cv = 1'b0; cin = 4'd0; tick(); tick();
      chk("vld_total", int'(if1.total_count), 3);
      chk("vld_hist2", hist1(2), 2);
      chk("vld_bad", int'(if1.bad_class), 1);
      chk("vld_err", int'(if1.error_count), 3);

      // MAX_EVENTS = 4 on the strobe-mode unit
      do_start(4'd7);
      cv = 1'b1; cin = 4'd1; repeat (6) tick();
      cv = 1'b0; cin = 4'd0; tick(); tick();
      chk("max_total", int'(if1.total_count), 4);
      chk("max_done", int'(if1.done), 1);
      do_start(4'd7);
      chk("max_restart_total", int'(if1.total_count), 0);
      chk("max_restart_busy", int'(if1.busy), 1);

      // Asynchronous reset mid-run
      do_start(4'd7);
      repeat (5) edge_event(4'd1);
      chk("pre_rst_err", int'(if0.error_count), 5);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("async_rst_dut0", (act0 == '0) ? 1 : 0, 1);
      chk("async_rst_dut1", (act1 == '0) ? 1 : 0, 1);
      @(posedge clk); #1;
      tick();
      reset = 1'b1;
      tick();

      // Start coincident with a pending event in both units
      do_start(4'd7);
      cin = 4'd3; cv = 1'b1; tick();
      start = 1'b1; cv = 1'b0; tick(); tick();
      start = 1'b0; cin = 4'd0; repeat (3) tick();
      chk("start_wins_dut0", int'(if0.total_count), 0);
      chk("start_wins_dut1", int'(if1.total_count), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 29) == 0);
         expc  = 4'($urandom_range(0, 15));
         cin   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
         cv    = 1'($urandom_range(0, 1));
         addr  = ($urandom_range(0, 24) == 0) ? 19'($urandom_range(AL + 1, 524287))
                                              : 19'($urandom_range(AL - 2000, AL));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
